// File: rtl/kernel_irq_gen_pkg.sv
// Shared definitions for the per-kernel interrupt source: state encoding and
// default widths used by kernel_irq_gen and its coalescing timer.
package kernel_irq_gen_pkg;

    localparam int STATE_W         = 3;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TMO_W       = 20;
    localparam int DEF_HOLDOFF_CYC = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_FIRE      = 3'd2,
        ST_WAIT_HOST = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_HOLDOFF   = 3'd5
    } irq_state_t;

endpackage

// File: rtl/kernel_irq_gen_timer.sv
// Coalescing timer: counts enabled cycles since the last clear, freezes while
// disabled, and flags when the programmed timeout is about to elapse.
module irq_coalesce_timer
    import kernel_irq_gen_pkg::*;
#(
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] timeout,
    output logic             expired
);

    logic [TMO_W-1:0] count;

    // Saturate instead of wrapping so a long freeze-free wait cannot re-arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TMO_W'(1);
        end
    end

    // A zero timeout disables the forced fire altogether.
    assign expired = (timeout != '0) && (count >= (timeout - TMO_W'(1)));

endmodule

// File: rtl/kernel_irq_gen.sv
// Per-kernel interrupt source: coalesces job_done events by count or timeout
// and drives the kernel_int / host_ack / kernel_ack pulse handshake.
module kernel_irq_gen
    import kernel_irq_gen_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TMO_W       = DEF_TMO_W,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
    input  logic               dma_axi_aclk,
    input  logic               dma_axi_aresetn,
    input  logic               job_done,
    input  logic               irq_enable,
    input  logic [CNT_W-1:0]   coalesce_cnt,
    input  logic [TMO_W-1:0]   coalesce_timeout,
    input  logic               host_ack,
    output logic               kernel_int,
    output logic               kernel_ack,
    output logic               irq_busy,
    output logic [CNT_W-1:0]   pending,
    output logic [CNT_W-1:0]   reported,
    output logic               overflow,
    output logic [STATE_W-1:0] fsm_state
);

    // Handshake: kernel_int is a one-cycle request; the host answers with a
    // one-cycle host_ack, accepted only while WAIT_HOST; kernel_ack then pulses
    // once to release the line. Every kernel_int gets exactly one kernel_ack.

    localparam int HO_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYC - 1);

    irq_state_t       state;
    logic [HO_W-1:0]  holdoff_cnt;

    logic             at_max;
    logic             sat_inc;
    logic [CNT_W-1:0] pending_next;
    logic [CNT_W-1:0] thresh;
    logic             tmo_expired;
    logic             fire_cond;
    logic             ack_accept;

    always_comb begin
        at_max       = (pending == '1);
        sat_inc      = job_done && at_max;
        pending_next = at_max ? pending : (pending + CNT_W'(job_done));
        thresh       = (coalesce_cnt == '0) ? CNT_W'(1) : coalesce_cnt;
        fire_cond    = irq_enable &&
                       ((pending_next >= thresh) ||
                        (tmo_expired && (pending_next != '0)));
        ack_accept   = (state == ST_WAIT_HOST) && host_ack;
    end

    // Timer is held at zero outside COLLECT, so every new batch starts from 0.
    irq_coalesce_timer #(
        .TMO_W (TMO_W)
    ) u_timer (
        .clk     (dma_axi_aclk),
        .rst_n   (dma_axi_aresetn),
        .clear   (state != ST_COLLECT),
        .enable  ((state == ST_COLLECT) && irq_enable),
        .timeout (coalesce_timeout),
        .expired (tmo_expired)
    );

    always_ff @(posedge dma_axi_aclk or negedge dma_axi_aresetn) begin
        if (!dma_axi_aresetn) begin
            state       <= ST_IDLE;
            holdoff_cnt <= '0;
            kernel_int  <= 1'b0;
            kernel_ack  <= 1'b0;
            irq_busy    <= 1'b0;
            pending     <= '0;
            reported    <= '0;
            overflow    <= 1'b0;
        end else begin
            kernel_int <= 1'b0;
            kernel_ack <= 1'b0;
            pending    <= pending_next;
            // A fresh saturation wins over a same-cycle clear.
            overflow   <= sat_inc || (overflow && !ack_accept);

            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (fire_cond) begin
                        state      <= ST_FIRE;
                        kernel_int <= 1'b1;
                        irq_busy   <= 1'b1;
                        reported   <= pending_next;
                        pending    <= '0;
                    end else if ((state == ST_IDLE) && job_done) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_FIRE: begin
                    state <= ST_WAIT_HOST;
                end
                ST_WAIT_HOST: begin
                    if (host_ack) begin
                        state      <= ST_RELEASE;
                        kernel_ack <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state       <= ST_HOLDOFF;
                    holdoff_cnt <= '0;
                end
                ST_HOLDOFF: begin
                    if (holdoff_cnt == HO_LAST) begin
                        state    <= (pending != '0) ? ST_COLLECT : ST_IDLE;
                        irq_busy <= 1'b0;
                    end else begin
                        holdoff_cnt <= holdoff_cnt + HO_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: doc/kernel_irq_gen.md
Name: kernel_irq_gen

Overview:
- Kernel-side interrupt source; produces the kernel_int / kernel_ack pulse pair consumed by the interrupt controller's per-kernel channel.
- Counts job-completion events and coalesces them by count threshold or timeout.
- Issues one kernel_int pulse per batch, waits for the host service acknowledge (register-write pulse), then issues kernel_ack to release the PCIe interrupt line.
- One instance per kernel (kernel0, kernel1).

Parameters:
CNT_W, 16, width of event counters and coalesce threshold
TMO_W, 20, width of coalescing timeout counter
HOLDOFF_CYC, 8, minimum idle cycles after kernel_ack before the next kernel_int

Ports:
dma_axi_aclk  in  1  clock
dma_axi_aresetn  in  1  asynchronous active-low reset
job_done  in  1  one-cycle pulse per completed kernel job
irq_enable  in  1  level; 0 suppresses firing (events still counted)
coalesce_cnt  in  CNT_W  event threshold; 0 treated as 1
coalesce_timeout  in  TMO_W  cycles from first pending event to forced fire; 0 disables timeout
host_ack  in  1  one-cycle pulse, host has serviced the interrupt
kernel_int  out  1  one-cycle interrupt request pulse
kernel_ack  out  1  one-cycle release pulse
irq_busy  out  1  high from FIRE through HOLDOFF inclusive
pending  out  CNT_W  events not yet reported
reported  out  CNT_W  event count carried by the current/last interrupt
overflow  out  1  sticky; pending saturated; cleared by accepted host_ack

Behaviour:
- Reset (async, dma_axi_aresetn=0): state IDLE; every output 0; timer 0. Reset mid-operation abandons the batch without a kernel_ack. The controller shares the same reset.
- States: IDLE, COLLECT, FIRE, WAIT_HOST, RELEASE, HOLDOFF. All outputs are registered.
- pending_next = pending + job_done, saturating at 2^CNT_W-1.
  - An increment attempted at saturation sets overflow.
  - Counting is active in every state.
- fire_cond = irq_enable && (pending_next >= max(coalesce_cnt,1) || (coalesce_timeout!=0 && timer >= coalesce_timeout-1 && pending_next!=0)).
- IDLE:
  - fire_cond -> FIRE.
  - Else job_done -> COLLECT with timer=0.
- COLLECT:
  - timer increments each cycle while irq_enable=1 and freezes while it is 0.
  - fire_cond -> FIRE.
- Transition into FIRE:
  - reported <= pending_next.
  - pending <= 0, or 1 if job_done arrives in that same cycle is impossible: the event is already included in pending_next.
- FIRE: kernel_int=1 for exactly this cycle, then -> WAIT_HOST.
  - Latency: job_done at cycle N with threshold 1 gives kernel_int at N+1.
- WAIT_HOST:
  - Hold until host_ack, then -> RELEASE and clear overflow.
  - irq_enable falling here does not cancel.
  - host_ack is ignored in all other states.
- RELEASE: kernel_ack=1 for exactly this cycle, then -> HOLDOFF with holdoff counter 0.
- HOLDOFF:
  - Stay HOLDOFF_CYC cycles.
  - Then pending!=0 -> COLLECT (timer=0), else -> IDLE.
  - Events arriving during FIRE..HOLDOFF go to the next batch.
- kernel_int and kernel_ack are never high in the same cycle. Exactly one kernel_ack per kernel_int.
- reported holds its value until the next FIRE entry.

Decomposition:
- Shared package/header:
  - state encoding constants (3-bit).
  - default CNT_W/TMO_W.
- One natural sub-module, irq_coalesce_timer: enable/clear/freeze counter with terminal-compare output.
- Saturating counter and FSM stay in kernel_irq_gen.

Test Plan:
- Threshold 1, timeout 0, enable=1: single job_done at cycle 10.
  - kernel_int at 11; reported=1, pending=0.
  - host_ack at 20 gives kernel_ack at 21.
  - irq_busy low at 21+8+1.
- Threshold 4, timeout 0: job_done at cycles 0,3,5.
  - No kernel_int.
  - 4th job_done at cycle 9 gives kernel_int at 10, reported=4.
- Threshold 100, timeout 50: one job_done at cycle 0.
  - kernel_int at cycle 51, reported=1.
  - irq_enable=0 for 10 cycles mid-collection delays it to 61.
- Events during WAIT_HOST: after fire (reported=2), 3 job_done pulses before host_ack.
  - reported stays 2 and pending=3.
  - After HOLDOFF, COLLECT resumes; threshold 3 fires immediately with reported=3.
- CNT_W=4: 20 job_done pulses with enable=0.
  - pending=15, overflow=1.
  - Enable gives kernel_int, reported=15.
  - host_ack clears overflow.
  - Stray host_ack in IDLE produces no kernel_ack.
- Assert dma_axi_aresetn=0 during WAIT_HOST.
  - All outputs 0 immediately (asynchronously).
  - No kernel_ack after release.
  - Next job_done behaves as a fresh start.
